l1_buyruk_onbellegi: RTL and testbench

Direct-mapped, read-only L1 instruction cache between the core's fetch port and main memory. It serves the core's `l1b_*` fetch interface: active-low chip select, word address, data, and a `bekle` stall. Hits return in the same cycle. Misses stall the core while a refill FSM fetches the whole line from main memory one word at a time.

---
 rtl/l1_buyruk_onbellegi_pkg.sv | 17 +
 rtl/l1_buyruk_onbellegi_if.sv | 25 ++
 rtl/l1_buyruk_onbellegi_veri_dizisi.sv | 28 ++
 rtl/l1_buyruk_onbellegi.sv | 143 ++++++++++++++
 tb/tb_l1_buyruk_onbellegi.sv | 250 +++++++++++++++++++++++++
 5 files changed

// File: rtl/l1_buyruk_onbellegi_pkg.sv
// Shared constants and types for the L1 instruction cache.
package l1_buyruk_onbellegi_pkg;

  localparam int unsigned L1B_SATIR_SAYISI = 16;
  localparam int unsigned L1B_SATIR_KELIME = 4;
  localparam int unsigned L1B_KELIME_W     = 32;

  typedef enum logic {
    BOSTA,
    DOLDUR
  } durum_e;

  function automatic int unsigned etiket_genisligi(int unsigned satir, int unsigned kelime);
    return L1B_KELIME_W - 2 - $clog2(satir) - $clog2(kelime);
  endfunction

endpackage

// File: rtl/l1_buyruk_onbellegi_if.sv
// Core fetch port and main-memory read port of the L1 instruction cache.
interface l1_buyruk_onbellegi_if;
  import l1_buyruk_onbellegi_pkg::*;

  logic                    cek_chip_select_n_i;
  logic [L1B_KELIME_W-1:0] cek_adres_i;
  logic                    cek_gecersizle_i;
  logic                    cek_bekle_o;
  logic [L1B_KELIME_W-1:0] cek_deger_o;
  logic                    anb_istek_o;
  logic [L1B_KELIME_W-1:0] anb_adres_o;
  logic                    anb_gecerli_i;
  logic [L1B_KELIME_W-1:0] anb_deger_i;

  modport slave (
    input  cek_chip_select_n_i, cek_adres_i, cek_gecersizle_i, anb_gecerli_i, anb_deger_i,
    output cek_bekle_o, cek_deger_o, anb_istek_o, anb_adres_o
  );

  modport master (
    output cek_chip_select_n_i, cek_adres_i, cek_gecersizle_i, anb_gecerli_i, anb_deger_i,
    input  cek_bekle_o, cek_deger_o, anb_istek_o, anb_adres_o
  );

endinterface

// File: rtl/l1_buyruk_onbellegi_veri_dizisi.sv
// Flop-based cache data array: one synchronous write port, one combinational read port.
module l1b_veri_dizisi
  import l1_buyruk_onbellegi_pkg::*;
#(
  parameter  int unsigned SATIR_SAYISI = L1B_SATIR_SAYISI,
  parameter  int unsigned SATIR_KELIME = L1B_SATIR_KELIME,
  localparam int unsigned IDX_W        = $clog2(SATIR_SAYISI),
  localparam int unsigned OFS_W        = $clog2(SATIR_KELIME)
) (
  input  logic                    clk_i,
  input  logic                    yaz_i,
  input  logic [IDX_W-1:0]        yaz_idx_i,
  input  logic [OFS_W-1:0]        yaz_ofs_i,
  input  logic [L1B_KELIME_W-1:0] yaz_deger_i,
  input  logic [IDX_W-1:0]        oku_idx_i,
  input  logic [OFS_W-1:0]        oku_ofs_i,
  output logic [L1B_KELIME_W-1:0] oku_deger_o
);

  logic [L1B_KELIME_W-1:0] veri_q [SATIR_SAYISI*SATIR_KELIME];

  always_ff @(posedge clk_i) begin
    if (yaz_i) veri_q[{yaz_idx_i, yaz_ofs_i}] <= yaz_deger_i;
  end

  assign oku_deger_o = veri_q[{oku_idx_i, oku_ofs_i}];

endmodule

// File: rtl/l1_buyruk_onbellegi.sv
// Direct-mapped read-only L1 instruction cache: zero-latency hits, word-by-word
// line refill from main memory on a miss.
module l1_buyruk_onbellegi
  import l1_buyruk_onbellegi_pkg::*;
#(
  parameter int unsigned SATIR_SAYISI = L1B_SATIR_SAYISI,
  parameter int unsigned SATIR_KELIME = L1B_SATIR_KELIME
) (
  input logic                  clk_i,
  input logic                  rst_i,
  l1_buyruk_onbellegi_if.slave bus
);

  localparam int unsigned IDX_W = $clog2(SATIR_SAYISI);
  localparam int unsigned OFS_W = $clog2(SATIR_KELIME);
  localparam int unsigned TAG_W = etiket_genisligi(SATIR_SAYISI, SATIR_KELIME);

  durum_e                  durum_q, durum_d;
  logic [OFS_W-1:0]        sayac_q, sayac_d;
  logic                    istek_q, istek_d;
  logic                    bekliyor_q, bekliyor_d;
  logic                    gec_bekle_q, gec_bekle_d;
  logic [L1B_KELIME_W-1:0] adres_q, adres_d;
  logic [L1B_KELIME_W-1:0] taban_q, taban_d;
  logic [SATIR_SAYISI-1:0] valid_q, valid_d;
  logic [TAG_W-1:0]        tag_q [SATIR_SAYISI];

  logic [OFS_W-1:0]        ofs;
  logic [IDX_W-1:0]        idx, taban_idx;
  logic [TAG_W-1:0]        etiket, taban_etiket;
  logic                    isabet, tag_yaz, veri_yaz, bekle;
  logic [L1B_KELIME_W-1:0] oku_deger, deger;

  assign ofs          = bus.cek_adres_i[2 +: OFS_W];
  assign idx          = bus.cek_adres_i[2+OFS_W +: IDX_W];
  assign etiket       = bus.cek_adres_i[L1B_KELIME_W-1 -: TAG_W];
  assign taban_idx    = taban_q[2+OFS_W +: IDX_W];
  assign taban_etiket = taban_q[L1B_KELIME_W-1 -: TAG_W];

  assign isabet = (durum_q == BOSTA) && !bus.cek_chip_select_n_i &&
                  valid_q[idx] && (tag_q[idx] == etiket);

  l1b_veri_dizisi #(
    .SATIR_SAYISI(SATIR_SAYISI),
    .SATIR_KELIME(SATIR_KELIME)
  ) u_veri (
    .clk_i       (clk_i),
    .yaz_i       (veri_yaz),
    .yaz_idx_i   (taban_idx),
    .yaz_ofs_i   (sayac_q),
    .yaz_deger_i (bus.anb_deger_i),
    .oku_idx_i   (idx),
    .oku_ofs_i   (ofs),
    .oku_deger_o (oku_deger)
  );

  always_comb begin
    durum_d     = durum_q;
    sayac_d     = sayac_q;
    istek_d     = 1'b0;
    bekliyor_d  = bekliyor_q;
    gec_bekle_d = gec_bekle_q;
    adres_d     = adres_q;
    taban_d     = taban_q;
    valid_d     = valid_q;
    tag_yaz     = 1'b0;
    veri_yaz    = 1'b0;
    bekle       = 1'b0;
    deger       = '0;
    unique case (durum_q)
      BOSTA: begin
        if (!bus.cek_chip_select_n_i) begin
          if (isabet) begin
            deger = oku_deger;
          end else begin
            bekle        = 1'b1;
            taban_d      = {etiket, idx, {(OFS_W+2){1'b0}}};
            valid_d[idx] = 1'b0;
            sayac_d      = '0;
            istek_d      = 1'b1;
            adres_d      = {etiket, idx, {(OFS_W+2){1'b0}}};
            durum_d      = DOLDUR;
          end
        end
        // Lookup above used the pre-clear valid bits; the clear lands at the edge.
        if (bus.cek_gecersizle_i) valid_d = '0;
      end
      DOLDUR: begin
        bekle = 1'b1;
        if (bus.cek_gecersizle_i) gec_bekle_d = 1'b1;
        if (istek_q) bekliyor_d = 1'b1;
        if (bekliyor_q && bus.anb_gecerli_i) begin
          veri_yaz   = 1'b1;
          bekliyor_d = 1'b0;
          if (&sayac_q) begin
            tag_yaz     = 1'b1;
            gec_bekle_d = 1'b0;
            durum_d     = BOSTA;
            if (gec_bekle_q || bus.cek_gecersizle_i) valid_d = '0;
            else valid_d[taban_idx] = 1'b1;
          end else begin
            sayac_d = sayac_q + OFS_W'(1);
            istek_d = 1'b1;
            adres_d = {taban_q[L1B_KELIME_W-1:2+OFS_W], sayac_q + OFS_W'(1), 2'b00};
          end
        end
      end
      default: durum_d = BOSTA;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      durum_q     <= BOSTA;
      sayac_q     <= '0;
      istek_q     <= 1'b0;
      bekliyor_q  <= 1'b0;
      gec_bekle_q <= 1'b0;
      adres_q     <= '0;
      taban_q     <= '0;
      valid_q     <= '0;
    end else begin
      durum_q     <= durum_d;
      sayac_q     <= sayac_d;
      istek_q     <= istek_d;
      bekliyor_q  <= bekliyor_d;
      gec_bekle_q <= gec_bekle_d;
      adres_q     <= adres_d;
      taban_q     <= taban_d;
      valid_q     <= valid_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (tag_yaz) tag_q[taban_idx] <= taban_etiket;
  end

  assign bus.cek_bekle_o = bekle;
  assign bus.cek_deger_o = deger;
  assign bus.anb_istek_o = istek_q;
  assign bus.anb_adres_o = adres_q;

endmodule

// File: tb/tb_l1_buyruk_onbellegi.sv
// Directed bench for the L1 instruction cache with a fixed-latency memory model.
module tb_l1_buyruk_onbellegi;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;

  l1_buyruk_onbellegi_if bus();

  l1_buyruk_onbellegi #(
    .SATIR_SAYISI(16),
    .SATIR_KELIME(4)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Memory model: answers each pulse after lat cycles with addr ^ 0xA5A5_0000.
  int          lat = 1;
  int          ncyc = 0;
  int          kalan = 0;
  int          cakisma = 0;
  logic [31:0] bek_adres = '0;
  logic [31:0] pulse_a[$];
  int          pulse_t[$];

  always @(negedge clk) begin
    ncyc++;
    bus.anb_gecerli_i = 1'b0;
    if (kalan > 0) begin
      kalan--;
      if (kalan == 0) begin
        bus.anb_gecerli_i = 1'b1;
        bus.anb_deger_i   = bek_adres ^ 32'hA5A5_0000;
      end
    end
    if (bus.anb_istek_o === 1'b1) begin
      if (kalan > 0) cakisma++;
      pulse_a.push_back(bus.anb_adres_o);
      pulse_t.push_back(ncyc);
      bek_adres = bus.anb_adres_o;
      kalan     = lat;
    end
  end

  task automatic oku(input logic [31:0] a, input int gec_at, input int chg_at,
                     input logic [31:0] chg_a, output logic [31:0] d,
                     output int cyc, output int base);
    @(negedge clk);
    bus.cek_chip_select_n_i = 1'b0;
    bus.cek_adres_i         = a;
    bus.cek_gecersizle_i    = (gec_at == 0);
    cyc = 0;
    #1;
    base = ncyc;
    while (bus.cek_bekle_o && cyc < 200) begin
      @(negedge clk);
      cyc++;
      bus.cek_gecersizle_i = (cyc == gec_at);
      if (cyc == chg_at) bus.cek_adres_i = chg_a;
      #1;
    end
    d = bus.cek_deger_o;
    bus.cek_gecersizle_i = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (bus.cek_bekle_o !== 1'b0) begin failures++; $display("FAIL reset_bekle: got %b expected 0", bus.cek_bekle_o); end
    checks++;
    if (bus.cek_deger_o !== 32'h0) begin failures++; $display("FAIL reset_deger: got %h expected 0", bus.cek_deger_o); end
    checks++;
    if (bus.anb_istek_o !== 1'b0) begin failures++; $display("FAIL reset_istek: got %b expected 0", bus.anb_istek_o); end
    checks++;
    if (bus.anb_adres_o !== 32'h0) begin failures++; $display("FAIL reset_adres: got %h expected 0", bus.anb_adres_o); end
  endtask

  task automatic test_cold_miss();
    logic [31:0] d;
    int cyc, base;
    lat = 1;
    pulse_a.delete(); pulse_t.delete();
    oku(32'h0000_0104, -1, -1, 32'h0, d, cyc, base);
    checks++;
    if (cyc !== 9) begin failures++; $display("FAIL cold_bekle_cycles: got %0d expected 9", cyc); end
    checks++;
    if (d !== 32'hA5A5_0104) begin failures++; $display("FAIL cold_data: got %h expected a5a50104", d); end
    checks++;
    if (pulse_a.size() !== 4) begin failures++; $display("FAIL cold_pulse_count: got %0d expected 4", pulse_a.size()); end
    for (int k = 0; k < 4 && k < pulse_a.size(); k++) begin
      checks++;
      if (pulse_a[k] !== 32'h100 + 32'(4*k)) begin
        failures++; $display("FAIL cold_pulse_addr%0d: got %h expected %h", k, pulse_a[k], 32'h100 + 32'(4*k));
      end
      checks++;
      if (pulse_t[k] - base !== 1 + 2*k) begin
        failures++; $display("FAIL cold_pulse_time%0d: got %0d expected %0d", k, pulse_t[k] - base, 1 + 2*k);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] d, a;
    int cyc, base;
    pulse_a.delete(); pulse_t.delete();
    for (int i = 0; i < 4; i++) begin
      a = 32'h100 + 32'(4*i);
      oku(a, -1, -1, 32'h0, d, cyc, base);
      checks++;
      if (cyc !== 0) begin failures++; $display("FAIL b2b_bekle%0d: got %0d expected 0", i, cyc); end
      checks++;
      if (d !== (a ^ 32'hA5A5_0000)) begin failures++; $display("FAIL b2b_data%0d: got %h expected %h", i, d, a ^ 32'hA5A5_0000); end
    end
    checks++;
    if (pulse_a.size() !== 0) begin failures++; $display("FAIL b2b_no_istek: got %0d expected 0", pulse_a.size()); end
  endtask

  task automatic test_conflict();
    logic [31:0] d;
    int cyc, base;
    oku(32'h0000_0110, -1, -1, 32'h0, d, cyc, base);
    checks++;
    if (cyc !== 9) begin failures++; $display("FAIL conf_first: got %0d expected 9", cyc); end
    oku(32'h0000_1110, -1, -1, 32'h0, d, cyc, base);
    checks++;
    if (cyc !== 9) begin failures++; $display("FAIL conf_second_miss: got %0d expected 9", cyc); end
    checks++;
    if (d !== 32'hA5A5_1110) begin failures++; $display("FAIL conf_second_data: got %h expected a5a51110", d); end
    oku(32'h0000_0110, -1, -1, 32'h0, d, cyc, base);
    checks++;
    if (cyc !== 9) begin failures++; $display("FAIL conf_reread: got %0d expected 9", cyc); end
    checks++;
    if (d !== 32'hA5A5_0110) begin failures++; $display("FAIL conf_reread_data: got %h expected a5a50110", d); end
  endtask

  task automatic test_invalidate();
    logic [31:0] d;
    int cyc, base;
    @(negedge clk);
    bus.cek_chip_select_n_i = 1'b0;
    bus.cek_adres_i         = 32'h0000_0110;
    bus.cek_gecersizle_i    = 1'b1;
    #1;
    checks++;
    if (bus.cek_bekle_o !== 1'b0) begin failures++; $display("FAIL inv_preclear_hit: got %b expected 0", bus.cek_bekle_o); end
    checks++;
    if (bus.cek_deger_o !== 32'hA5A5_0110) begin failures++; $display("FAIL inv_preclear_data: got %h expected a5a50110", bus.cek_deger_o); end
    oku(32'h0000_0110, -1, -1, 32'h0, d, cyc, base);
    checks++;
    if (cyc !== 9) begin failures++; $display("FAIL inv_bosta_miss: got %0d expected 9", cyc); end
    // Pulse during refill: held request misses again on return, refilling twice.
    pulse_a.delete(); pulse_t.delete();
    oku(32'h0000_0200, 3, -1, 32'h0, d, cyc, base);
    checks++;
    if (cyc !== 18) begin failures++; $display("FAIL inv_doldur_cycles: got %0d expected 18", cyc); end
    checks++;
    if (pulse_a.size() !== 8) begin failures++; $display("FAIL inv_doldur_pulses: got %0d expected 8", pulse_a.size()); end
    checks++;
    if (d !== 32'hA5A5_0200) begin failures++; $display("FAIL inv_doldur_data: got %h expected a5a50200", d); end
  endtask

  task automatic test_reset_mid_refill();
    logic [31:0] d;
    int cyc, base;
    lat = 3;
    pulse_a.delete(); pulse_t.delete();
    @(negedge clk);
    bus.cek_chip_select_n_i = 1'b0;
    bus.cek_adres_i         = 32'h0000_0300;
    repeat (6) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    bus.cek_chip_select_n_i = 1'b1;
    #1;
    checks++;
    if (bus.anb_istek_o !== 1'b0) begin failures++; $display("FAIL rstmid_istek: got %b expected 0", bus.anb_istek_o); end
    checks++;
    if (bus.cek_bekle_o !== 1'b0) begin failures++; $display("FAIL rstmid_bekle: got %b expected 0", bus.cek_bekle_o); end
    repeat (8) @(negedge clk);
    checks++;
    if (pulse_a.size() !== 2) begin failures++; $display("FAIL rstmid_no_more_istek: got %0d expected 2", pulse_a.size()); end
    pulse_a.delete(); pulse_t.delete();
    oku(32'h0000_0300, -1, -1, 32'h0, d, cyc, base);
    checks++;
    if (cyc !== 17) begin failures++; $display("FAIL rstmid_refill_cycles: got %0d expected 17", cyc); end
    checks++;
    if (pulse_a.size() !== 4) begin failures++; $display("FAIL rstmid_refill_pulses: got %0d expected 4", pulse_a.size()); end
    checks++;
    if (d !== 32'hA5A5_0300) begin failures++; $display("FAIL rstmid_data: got %h expected a5a50300", d); end
  endtask

  task automatic test_variable_latency();
    logic [31:0] d;
    int cyc, base;
    lat = 3;
    cakisma = 0;
    pulse_a.delete(); pulse_t.delete();
    oku(32'h0000_0400, -1, 5, 32'h0000_0524, d, cyc, base);
    checks++;
    if (cyc !== 34) begin failures++; $display("FAIL varlat_cycles: got %0d expected 34", cyc); end
    checks++;
    if (d !== 32'hA5A5_0524) begin failures++; $display("FAIL varlat_data: got %h expected a5a50524", d); end
    checks++;
    if (pulse_a.size() !== 8) begin failures++; $display("FAIL varlat_pulses: got %0d expected 8", pulse_a.size()); end
    for (int k = 0; k < 8 && k < pulse_a.size(); k++) begin
      checks++;
      if (pulse_a[k] !== ((k < 4) ? 32'h400 : 32'h520) + 32'(4*(k%4))) begin
        failures++; $display("FAIL varlat_addr%0d: got %h", k, pulse_a[k]);
      end
    end
    checks++;
    if (pulse_t.size() > 4 && (pulse_t[4] - base !== 18)) begin
      failures++; $display("FAIL varlat_second_start: got %0d expected 18", pulse_t[4] - base);
    end
    checks++;
    if (cakisma !== 0) begin failures++; $display("FAIL varlat_outstanding: got %0d expected 0", cakisma); end
    oku(32'h0000_0408, -1, -1, 32'h0, d, cyc, base);
    checks++;
    if (cyc !== 0) begin failures++; $display("FAIL varlat_orig_line_hit: got %0d expected 0", cyc); end
    checks++;
    if (d !== 32'hA5A5_0408) begin failures++; $display("FAIL varlat_orig_data: got %h expected a5a50408", d); end
  endtask

  initial begin
    bus.cek_chip_select_n_i = 1'b1;
    bus.cek_adres_i         = '0;
    bus.cek_gecersizle_i    = 1'b0;
    bus.anb_gecerli_i       = 1'b0;
    bus.anb_deger_i         = '0;
    test_reset();
    test_cold_miss();
    test_back_to_back();
    test_conflict();
    test_invalidate();
    test_reset_mid_refill();
    test_variable_latency();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
